// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests to instruction
// memory, buffers {pc, instr} in a prefetch FIFO for decode and flushes on redirect.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   CREDIT   = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic          run;
    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW-1:0] pcq_rd, pcq_wr;

    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [31:0]   pcq        [FIFO_DEPTH];

    logic          req_fire;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_tgt;

    // run holds requests off until the first clock edge after reset release
    always_comb begin
        redirect_tgt   = redirect_pc & 32'hFFFF_FFFC;
        imem_req_valid = run && !redirect_valid
                         && (({1'b0, outstanding} + {1'b0, count}) < CREDIT);
        imem_req_addr  = pc;
        req_fire       = imem_req_valid && imem_req_ready;
        push           = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
        id_valid       = (count != '0);
        pop            = id_valid && id_ready && !redirect_valid;
        id_instr       = id_valid ? fifo_instr[rd_ptr] : NOP_INSTR;
        id_pc          = id_valid ? fifo_pc[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq[pcq_wr] <= pc;
        end
        if (push) begin
            fifo_pc[wr_ptr]    <= pcq[pcq_rd];
            fifo_instr[wr_ptr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc     <= redirect_tgt;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                pcq_rd <= '0;
                pcq_wr <= '0;
                // outstanding already includes responses marked for dropping, so every
                // word still in flight after this edge is stale, whatever drop_cnt was
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    pc     <= pc + 32'd4;
                    pcq_wr <= pcq_wr + AW'(1);
                end
                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    pcq_rd <= pcq_rd + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == FULL_CNT)));

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: a memory model answers requests in order,
// and decode must see exactly the words fetched since the last redirect, in order.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    instr_fetch #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned cyc;
    } mreq_t;

    exp_t        exp_q[$];
    mreq_t       mem_q[$];
    logic [31:0] next_fetch;
    int unsigned cyc;
    int unsigned acc_cnt;
    int unsigned pops;
    int          vectors;
    int          miscompares;

    // stimulus knobs, percent probabilities
    int unsigned p_rr, p_rsp, p_idr, p_redir;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_id_valid", {31'b0, id_valid}, 32'd0);
        check("rst_id_instr", id_instr, NOP);
        check("rst_id_pc", id_pc, 32'd0);
    endtask

    task automatic clear_models();
        exp_q.delete();
        mem_q.delete();
        next_fetch = RESET_PC;
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        else t = $urandom;
        return t;
    endfunction

    task automatic step(input bit force_redir = 1'b0, input logic [31:0] force_pc = '0);
        @(negedge clk);
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mem_q.size() != 0 && mem_q[0].cyc < cyc && $urandom_range(99) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        imem_req_ready = ($urandom_range(99) < p_rr);
        id_ready       = ($urandom_range(99) < p_idr);
        redirect_valid = force_redir || ($urandom_range(99) < p_redir);
        redirect_pc    = force_redir ? force_pc : rand_target();
        #1;
        if (redirect_valid) begin
            check("req_during_redirect", {31'b0, imem_req_valid}, 32'd0);
            exp_q.delete();
            next_fetch = redirect_pc & 32'hFFFF_FFFC;
        end else if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, next_fetch);
            mem_q.push_back('{addr: imem_req_addr, cyc: cyc});
            check("credit", 32'(mem_q.size() <= DEPTH), 32'd1);
            exp_q.push_back('{pc: next_fetch, instr: word(next_fetch)});
            next_fetch += 32'd4;
            acc_cnt++;
        end
    endtask

    // monitor: pops the scoreboard on decode handshakes and checks hold/flush rules
    logic        m_rv, m_rr, m_idv, m_pop, m_redir;
    logic [31:0] m_addr, m_pc, m_instr;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            m_rv = 1'b0; m_idv = 1'b0; m_redir = 1'b0; m_pop = 1'b0; m_rr = 1'b0;
        end else begin
            if (id_valid && id_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL dec_unexpected: got pc %h, required no instruction", id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("dec_pc", id_pc, e.pc);
                    check("dec_instr", id_instr, e.instr);
                    pops++;
                end
            end
            if (!id_valid) begin
                check("idle_instr", id_instr, NOP);
                check("idle_pc", id_pc, 32'd0);
            end
            if (m_redir) begin
                check("flush_empty", {31'b0, id_valid}, 32'd0);
            end else if (m_idv && !m_pop) begin
                check("hold_valid", {31'b0, id_valid}, 32'd1);
                check("hold_pc", id_pc, m_pc);
                check("hold_instr", id_instr, m_instr);
            end
            if (m_rv && !m_rr && !redirect_valid) begin
                check("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
                check("req_hold_addr", imem_req_addr, m_addr);
            end
            m_rv    = imem_req_valid;
            m_rr    = imem_req_ready;
            m_addr  = imem_req_addr;
            m_idv   = id_valid;
            m_pop   = id_valid && id_ready && !redirect_valid;
            m_redir = redirect_valid;
            m_pc    = id_pc;
            m_instr = id_instr;
        end
    end

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; acc_cnt = 0; pops = 0;
        rst_n = 1'b0;
        idle_inputs();
        clear_models();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // decode stalled: only DEPTH requests may be issued
        p_rr = 100; p_rsp = 100; p_idr = 0; p_redir = 0;
        acc_cnt = 0;
        repeat (10) step();
        check("fill_reqs", acc_cnt, DEPTH);
        p_idr = 100;
        repeat (20) step();

        // memory stalled: request must be held without advancing
        p_rr = 0;
        acc_cnt = 0;
        repeat (5) step();
        check("stall_reqs", acc_cnt, 32'd0);
        p_rr = 100;
        repeat (20) step();

        // two requests in flight, then redirect to an unaligned target
        p_rsp = 0;
        repeat (4) step();
        check("two_outstanding", 32'(mem_q.size()), DEPTH);
        p_rsp = 100;
        step(1'b1, 32'h0000_0102);
        repeat (20) step();

        p_rr = 70; p_rsp = 75; p_idr = 70; p_redir = 4;
        repeat (1500) step();

        // asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        idle_inputs();
        clear_models();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        repeat (1500) step();
        check("liveness", 32'(pops >= 200), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
